// File: rtl/pu_tag_lookup_arb.sv
// Round-robin arbiter sharing one tag lookup engine among NUM_REQ requesters.
// Paces key issue, caps in-flight lookups and retires them on engine status.
`ifndef PU_ID_NBITS
`define PU_ID_NBITS 3
`endif
`ifndef TAG_KEY_NBITS
`define TAG_KEY_NBITS 8
`endif

module pu_tag_req_slot (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic retire,
  output logic busy,
  output logic ready,
  output logic done
);
  // grant needs busy low and retire needs busy high, so they never coincide here
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      ready <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= grant;
      done  <= retire;
      if (grant)       busy <= 1'b1;
      else if (retire) busy <= 1'b0;
    end
  end
endmodule

module pu_tag_lookup_arb #(
  parameter int NUM_REQ         = 4,
  parameter int PU_ID_NBITS     = `PU_ID_NBITS,
  parameter int TAG_KEY_NBITS   = `TAG_KEY_NBITS,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ISSUE_GAP       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*TAG_KEY_NBITS-1:0]     req_key,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   req_done,
  output logic                                 tag_key_valid,
  output logic [TAG_KEY_NBITS-1:0]             tag_key,
  output logic [PU_ID_NBITS-1:0]               tag_pid,
  input  logic                                 tag_lookup_status_valid,
  input  logic [PU_ID_NBITS-1:0]               tag_lookup_status_pid,
  output logic [NUM_REQ-1:0]                   busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_status
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  logic [PW-1:0]            rr_ptr;
  logic [GW-1:0]            gap_cnt;
  logic [NUM_REQ-1:0]       eligible, grant, retire;
  logic [PW-1:0]            gidx;
  logic [TAG_KEY_NBITS-1:0] sel_key;
  logic                     issue_ok, found, st_bad;
  int                       idx;

  always_comb begin
    eligible = req_valid & ~busy;
    issue_ok = (gap_cnt == '0) && (int'(outstanding) < MAX_OUTSTANDING);
    grant    = '0;
    gidx     = '0;
    sel_key  = '0;
    found    = 1'b0;
    idx      = 0;
    // first eligible index walking up from rr_ptr, wrapping
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (issue_ok && !found && eligible[idx]) begin
        found   = 1'b1;
        gidx    = PW'(idx);
        sel_key = req_key[idx*TAG_KEY_NBITS +: TAG_KEY_NBITS];
      end
    end
    if (found) grant[gidx] = 1'b1;

    retire = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (tag_lookup_status_valid && int'(tag_lookup_status_pid) == i && busy[i])
        retire[i] = 1'b1;
    st_bad = tag_lookup_status_valid && (retire == '0);
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    pu_tag_req_slot u_slot (
      .clk    (clk),
      .rst    (rst),
      .grant  (grant[i]),
      .retire (retire[i]),
      .busy   (busy[i]),
      .ready  (req_ready[i]),
      .done   (req_done[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      gap_cnt       <= '0;
      outstanding   <= '0;
      err_status    <= 1'b0;
      tag_key_valid <= 1'b0;
      tag_key       <= '0;
      tag_pid       <= '0;
    end else begin
      tag_key_valid <= found;
      if (found) begin
        tag_key <= sel_key;
        tag_pid <= PU_ID_NBITS'(gidx);
        rr_ptr  <= (int'(gidx) == NUM_REQ-1) ? '0 : gidx + 1'b1;
        gap_cnt <= GW'(ISSUE_GAP-1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      // grant and retire together cancel out
      if (found && (retire == '0))
        outstanding <= outstanding + 1'b1;
      else if (!found && (retire != '0))
        outstanding <= outstanding - 1'b1;
      if (st_bad) err_status <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pu_tag_lookup_arb.sv
// Bench for pu_tag_lookup_arb: directed vector table plus random traffic
// checked against a behavioural model of the arbitration rules.
module tb_pu_tag_lookup_arb;
  localparam int N = 4, PIDW = 3, KW = 8, MAXO = 2, GAP = 8;
  localparam int OW = $clog2(MAXO+1);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*KW-1:0]   req_key;
  logic [N-1:0]      req_ready, req_done, busy;
  logic              tag_key_valid;
  logic [KW-1:0]     tag_key;
  logic [PIDW-1:0]   tag_pid;
  logic              tag_lookup_status_valid;
  logic [PIDW-1:0]   tag_lookup_status_pid;
  logic [OW-1:0]     outstanding;
  logic              err_status;

  int n_cmp = 0, n_bad = 0;

  pu_tag_lookup_arb #(.NUM_REQ(N), .PU_ID_NBITS(PIDW), .TAG_KEY_NBITS(KW),
                      .MAX_OUTSTANDING(MAXO), .ISSUE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key),
    .req_ready(req_ready), .req_done(req_done), .tag_key_valid(tag_key_valid),
    .tag_key(tag_key), .tag_pid(tag_pid),
    .tag_lookup_status_valid(tag_lookup_status_valid),
    .tag_lookup_status_pid(tag_lookup_status_pid),
    .busy(busy), .outstanding(outstanding), .err_status(err_status));

  always #5 clk = ~clk;

  // reference model state
  bit            m_busy[N];
  int            m_out, m_gap, m_rr, m_pid;
  bit            m_err, m_tkv;
  logic [KW-1:0] m_key;
  logic [N-1:0]  m_rdy, m_done;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 0;
    m_out = 0; m_gap = 0; m_rr = 0; m_pid = 0; m_err = 0; m_tkv = 0;
    m_key = '0; m_rdy = '0; m_done = '0;
  endtask

  // advance model from the inputs currently driven, then clock the DUT
  task automatic step();
    int g, r;
    g = -1; r = -1;
    if (rst) model_reset();
    else begin
      if (m_gap == 0 && m_out < MAXO)
        for (int k = 0; k < N; k++) begin
          int i = (m_rr + k) % N;
          if (g < 0 && req_valid[i] && !m_busy[i]) g = i;
        end
      if (tag_lookup_status_valid) begin
        if (int'(tag_lookup_status_pid) < N && m_busy[int'(tag_lookup_status_pid)])
          r = int'(tag_lookup_status_pid);
        else
          m_err = 1;
      end
      m_rdy = '0; m_done = '0; m_tkv = (g >= 0);
      if (g >= 0) begin
        m_rdy[g] = 1'b1; m_key = req_key[g*KW +: KW]; m_pid = g;
        m_busy[g] = 1; m_out++; m_gap = GAP-1; m_rr = (g+1) % N;
      end else if (m_gap > 0) m_gap--;
      if (r >= 0) begin m_done[r] = 1'b1; m_busy[r] = 0; m_out--; end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_model(int cyc);
    logic [N-1:0] mb;
    bit bad;
    for (int i = 0; i < N; i++) mb[i] = m_busy[i];
    n_cmp++;
    bad = (tag_key_valid !== m_tkv) || (req_ready !== m_rdy) || (req_done !== m_done) ||
          (busy !== mb) || (outstanding !== OW'(m_out)) || (err_status !== m_err);
    if (m_tkv && ((tag_key !== m_key) || (tag_pid !== PIDW'(m_pid)))) bad = 1;
    if (bad) begin
      n_bad++;
      $display("FAIL rand cyc=%0d got tkv=%b key=%h pid=%0d rdy=%b done=%b busy=%b out=%0d err=%b want tkv=%b key=%h pid=%0d rdy=%b done=%b busy=%b out=%0d err=%b",
               cyc, tag_key_valid, tag_key, tag_pid, req_ready, req_done, busy, outstanding, err_status,
               m_tkv, m_key, m_pid, m_rdy, m_done, mb, m_out, m_err);
    end
  endtask

  typedef struct {
    bit            rst;
    logic [N-1:0]  vld;
    logic [N*KW-1:0] keys;
    bit            sv;
    logic [PIDW-1:0] spid;
    int            rep;
    bit            e_tkv;
    logic [KW-1:0] e_key;
    int            e_pid;
    logic [N-1:0]  e_rdy, e_done, e_busy;
    int            e_out;
    bit            e_err;
  } vec_t;

  task automatic check_row(int r, vec_t v);
    bit bad;
    n_cmp++;
    bad = (tag_key_valid !== v.e_tkv) || (req_ready !== v.e_rdy) || (req_done !== v.e_done) ||
          (busy !== v.e_busy) || (outstanding !== OW'(v.e_out)) || (err_status !== v.e_err);
    if ((v.e_tkv || v.rst) && ((tag_key !== v.e_key) || (tag_pid !== PIDW'(v.e_pid)))) bad = 1;
    if (bad) begin
      n_bad++;
      $display("FAIL row%0d got tkv=%b key=%h pid=%0d rdy=%b done=%b busy=%b out=%0d err=%b want tkv=%b key=%h pid=%0d rdy=%b done=%b busy=%b out=%0d err=%b",
               r, tag_key_valid, tag_key, tag_pid, req_ready, req_done, busy, outstanding, err_status,
               v.e_tkv, v.e_key, v.e_pid, v.e_rdy, v.e_done, v.e_busy, v.e_out, v.e_err);
    end
  endtask

  initial begin
    vec_t tbl[$];
    logic [N*KW-1:0] K;
    K = 32'h44A52211;  // slot3=44 slot2=A5 slot1=22 slot0=11
    rst = 1'b1; req_valid = '0; req_key = '0;
    tag_lookup_status_valid = 1'b0; tag_lookup_status_pid = '0;
    model_reset();

    //            rst vld      keys sv spid rep tkv key   pid rdy      done     busy     out err
    tbl.push_back('{1, 4'b0000, K, 0, 0, 2,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    tbl.push_back('{0, 4'b0000, K, 0, 0, 8,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    // single request from requester 2
    tbl.push_back('{0, 4'b0100, K, 0, 0, 1,  1, 8'hA5, 2, 4'b0100, 4'b0000, 4'b0100, 1, 0});
    tbl.push_back('{0, 4'b0000, K, 0, 0, 28, 0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0100, 1, 0});
    tbl.push_back('{0, 4'b0000, K, 1, 2, 1,  0, 8'h00, 0, 4'b0000, 4'b0100, 4'b0000, 0, 0});
    tbl.push_back('{0, 4'b0000, K, 0, 0, 1,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    // bad status: idle pid, then out-of-range pid
    tbl.push_back('{0, 4'b0000, K, 1, 3, 1,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1});
    tbl.push_back('{0, 4'b0000, K, 1, 5, 1,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1});
    tbl.push_back('{0, 4'b0000, K, 0, 0, 3,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1});
    tbl.push_back('{1, 4'b0000, K, 0, 0, 1,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    // pacing, then grant to 1 coinciding with retire of 0
    tbl.push_back('{0, 4'b0011, K, 0, 0, 1,  1, 8'h11, 0, 4'b0001, 4'b0000, 4'b0001, 1, 0});
    tbl.push_back('{0, 4'b0010, K, 0, 0, 7,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0001, 1, 0});
    tbl.push_back('{0, 4'b0011, K, 1, 0, 1,  1, 8'h22, 1, 4'b0010, 4'b0001, 4'b0010, 1, 0});
    tbl.push_back('{0, 4'b0001, K, 0, 0, 1,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0010, 1, 0});
    tbl.push_back('{0, 4'b0001, K, 0, 0, 6,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0010, 1, 0});
    tbl.push_back('{0, 4'b0001, K, 0, 0, 1,  1, 8'h11, 0, 4'b0001, 4'b0000, 4'b0011, 2, 0});
    // outstanding cap holds off 2 and 3 until a slot frees
    tbl.push_back('{0, 4'b1100, K, 0, 0, 12, 0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0011, 2, 0});
    tbl.push_back('{0, 4'b1100, K, 1, 0, 1,  0, 8'h00, 0, 4'b0000, 4'b0001, 4'b0010, 1, 0});
    tbl.push_back('{0, 4'b1100, K, 0, 0, 1,  1, 8'hA5, 2, 4'b0100, 4'b0000, 4'b0110, 2, 0});
    // reset mid-flight with gap_cnt at 5
    tbl.push_back('{0, 4'b1000, K, 0, 0, 2,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0110, 2, 0});
    tbl.push_back('{1, 4'b1000, K, 0, 0, 1,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    tbl.push_back('{0, 4'b1000, K, 0, 0, 1,  1, 8'h44, 3, 4'b1000, 4'b0000, 4'b1000, 1, 0});
    tbl.push_back('{0, 4'b0000, K, 0, 0, 1,  0, 8'h00, 0, 4'b0000, 4'b0000, 4'b1000, 1, 0});

    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        rst = tbl[r].rst; req_valid = tbl[r].vld; req_key = tbl[r].keys;
        tag_lookup_status_valid = tbl[r].sv; tag_lookup_status_pid = tbl[r].spid;
        step();
      end
      check_row(r, tbl[r]);
    end

    // random traffic against the model
    rst = 1'b1; req_valid = '0; tag_lookup_status_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      int pick;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_key[i*KW +: KW] = KW'($urandom);
        end
      end
      tag_lookup_status_valid = 1'b0;
      if ($urandom_range(4) == 0) begin
        pick = int'($urandom_range(N-1));
        if (m_busy[pick]) begin
          tag_lookup_status_valid = 1'b1;
          tag_lookup_status_pid = PIDW'(pick);
        end
      end else if ($urandom_range(60) == 0) begin
        tag_lookup_status_valid = 1'b1;
        tag_lookup_status_pid = PIDW'($urandom_range(7));
      end
      if ($urandom_range(700) == 0) begin
        rst = 1'b1; req_valid = '0;
      end else rst = 1'b0;
      step();
      check_model(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pu_tag_lookup_arb.md
# pu_tag_lookup_arb

Shares one tag lookup engine among NUM_REQ processing-unit requesters. Each requester may have at most one lookup in flight. The arbiter picks requesters round-robin and paces key issue to the engine's eight-read-per-key value-table throughput. It caps outstanding lookups so the engine's key latency FIFO cannot overflow, and it retires each lookup on the engine's per-lookup status return.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; requester index is used as the lookup pid.
- PU_ID_NBITS, `PU_ID_NBITS: pid width; must satisfy NUM_REQ <= 2^PU_ID_NBITS.
- TAG_KEY_NBITS, `TAG_KEY_NBITS: key width.
- MAX_OUTSTANDING, 2: maximum lookups issued but not yet retired.
- ISSUE_GAP, 8: minimum cycles between consecutive key issues; must be >= 1.

Ports:
- clk  in  1  clock; the block uses this single clock.
- `RESET_SIG (rst)  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_REQ  per-requester lookup request; held high until the corresponding req_ready pulse.
- req_key  in  NUM_REQ*TAG_KEY_NBITS  per-requester key; slice i belongs to requester i; held stable while req_valid[i] is high.
- req_ready  out  NUM_REQ  one-cycle accept pulse.
- req_done  out  NUM_REQ  one-cycle pulse when the requester's lookup retires.
- tag_key_valid  out  1  key issue strobe to the engine.
- tag_key  out  TAG_KEY_NBITS  issued key.
- tag_pid  out  PU_ID_NBITS  issued pid, equal to the granted index.
- tag_lookup_status_valid  in  1  engine retire strobe; one per issued key.
- tag_lookup_status_pid  in  PU_ID_NBITS  pid of the retiring lookup.
- busy  out  NUM_REQ  per-requester in-flight flag.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight lookup count.
- err_status  out  1  sticky flag: a status was received for a pid that was not busy, or for a pid >= NUM_REQ.

## Operation
- Requester i is eligible when req_valid[i] is high and the registered busy[i] is low.
- An issue is allowed when gap_cnt==0, outstanding < MAX_OUTSTANDING and at least one requester is eligible.
- Arbitration is round-robin:
  - rr_ptr names the highest-priority index.
  - The search order is rr_ptr, rr_ptr+1, and so on, wrapping modulo NUM_REQ.
  - On a grant to index g, rr_ptr becomes (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when no grant occurs.
- On a grant to g:
  - The next cycle drives tag_key_valid=1, tag_key=req_key[g] (sampled in the decision cycle), tag_pid=g and req_ready[g]=1.
  - busy[g] is set.
  - gap_cnt is loaded with ISSUE_GAP-1.
  - outstanding increments.
- gap_cnt decrements by 1 per cycle while nonzero, saturating at 0.
- On tag_lookup_status_valid with pid p < NUM_REQ and busy[p]=1:
  - busy[p] clears.
  - outstanding decrements.
  - req_done[p] pulses one cycle later.
- On tag_lookup_status_valid with p >= NUM_REQ or busy[p]=0:
  - err_status is set and remains set until reset.
  - busy and outstanding are unchanged.
  - No req_done pulse is generated.
- Grant and retire in the same cycle leave outstanding unchanged.
- If busy[i] clears in the same cycle that req_valid[i] is high, requester i is not eligible until the following cycle.
- Retire for requester i in the same cycle as a grant to requester j != i: both take effect.
- outstanding never exceeds MAX_OUTSTANDING and never underflows.

## Timing
- Every output is registered.
- Reset values: req_ready=0, req_done=0, tag_key_valid=0, tag_key=0, tag_pid=0, busy=0, outstanding=0, err_status=0, rr_ptr=0, gap_cnt=0.
- Request-to-issue latency: 1 cycle from the first cycle req_valid is high with the issue conditions met.
- With continuous requests from all requesters, tag_key_valid pulses exactly every ISSUE_GAP cycles, subject to the outstanding cap.
- Retire-to-done latency: 1 cycle.
- A freed outstanding slot is usable in the cycle after the status.
- Reset mid-operation:
  - All state clears on the next edge.
  - Pending grants are dropped.
  - Requesters must re-present their requests.
  - The engine shares the same reset, so no stale status is expected.

## Test plan
- Single request, NUM_REQ=4, ISSUE_GAP=8:
  - Stimulus: req_valid[2]=1 with key 0xA5 at cycle 10.
  - Response: at cycle 11, tag_key_valid=1, tag_key=0xA5, tag_pid=2, req_ready[2]=1 and busy[2]=1.
  - Then status pid=2 at cycle 40 gives req_done[2] at cycle 41, busy[2]=0 and outstanding=0.
- Round-robin pacing:
  - Stimulus: all four req_valid high at cycle 0, MAX_OUTSTANDING=4, no status returned.
  - Response: grants to 0, 1, 2, 3 at cycles 1, 9, 17, 25; outstanding=4; no further tag_key_valid.
- Outstanding cap:
  - Stimulus: MAX_OUTSTANDING=2 with all requesters asserting.
  - Response: two issues, then stall.
  - A status for pid 0 at cycle 30 gives an issue to requester 2 at cycle 32.
- Simultaneous grant and retire:
  - Stimulus: status pid 0 in the same cycle as the grant decision for requester 1.
  - Response: outstanding unchanged, req_done[0] pulses, and requester 0 is not re-granted in that cycle.
- Bad status:
  - Stimulus: status with pid=3 while busy[3]=0, then status with pid=5.
  - Response: err_status=1 and stays set; outstanding unchanged; no req_done pulse.
- Reset mid-flight:
  - Stimulus: rst high for one cycle with outstanding=2 and gap_cnt=5.
  - Response: all outputs at their reset values on the next cycle.
  - A new request issues 1 cycle after it is presented, without waiting on the old gap.
